mbist_march_ctrl: RTL

Parametrised successor to the single-pass MBIST controller. Sequences a March test of NUM_ELEMS elements. Each element reloads the address counter (ld) and runs it to terminal count (cout) while holding the memory mux in test mode (NbarT). Adds a March element index, sticky fail capture, a saturating fail counter, optional stop-on-first-fail, and done/busy status for the BIST wrapper.

---
 rtl/mbist_march_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
//   Sequences a March test of NUM_ELEMS elements for the BIST wrapper. Each
//   element reloads the address/pattern counters (ld), then runs them until
//   the address counter reports terminal count (cout) with the memory mux held
//   in test mode (NbarT). Comparator mismatches (err) set a sticky fail flag
//   and bump a saturating counter; with STOP_ON_FAIL=1 the first err ends the
//   run.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   start     in   run request (honoured in IDLE and DONE only)
//   cout      in   address counter terminal count for the current element
//   err       in   comparator mismatch for the current access
//   ld        out  load/reload address and pattern counters
//   NbarT     out  memory mux select, 0 = normal, 1 = test
//   elem_idx  out  current March element, drives the pattern generator
//   busy      out  run in progress (LOAD or TEST)
//   done      out  run complete, held until the next start
//   fail      out  sticky: at least one err in the current or last run
//   fail_cnt  out  number of err cycles, saturating at all-ones
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | out of reset, waiting for start; counters held in load
// LOAD  | one-cycle reload of the counters for the current element
// TEST  | element running; watching err and cout
// DONE  | run finished; elem_idx, fail and fail_cnt held for readout

package mbist_march_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    TEST = 2'd2,
    DONE = 2'd3
  } march_state_t;
endpackage

module mbist_march_ctrl
  import mbist_march_pkg::*;
#(
  parameter int NUM_ELEMS    = 6,
  parameter int ELEM_W       = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1,
  parameter int STOP_ON_FAIL = 1,
  parameter int FAIL_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cout,
  input  logic                  err,
  output logic                  ld,
  output logic                  NbarT,
  output logic [ELEM_W-1:0]     elem_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  localparam logic [ELEM_W-1:0]     LAST_ELEM = ELEM_W'(NUM_ELEMS - 1);
  localparam logic [FAIL_CNT_W-1:0] FAIL_MAX  = '1;
  localparam logic                  STOP_EN   = (STOP_ON_FAIL != 0);

  march_state_t          state;
  march_state_t          state_nxt;
  logic [ELEM_W-1:0]     elem_nxt;
  logic                  fail_nxt;
  logic [FAIL_CNT_W-1:0] cnt_nxt;

  // Next-state and datapath decisions. The err update is applied before the
  // cout decision so a mismatch on the last access of an element is always
  // counted, and a stopping err wins over a simultaneous cout.
  always_comb begin
    state_nxt = state;
    elem_nxt  = elem_idx;
    fail_nxt  = fail;
    cnt_nxt   = fail_cnt;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = LOAD;
          elem_nxt  = '0;
          fail_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      end

      LOAD: begin
        state_nxt = TEST;
      end

      TEST: begin
        if (err) begin
          fail_nxt = 1'b1;
          if (fail_cnt != FAIL_MAX) begin
            cnt_nxt = fail_cnt + FAIL_CNT_W'(1);
          end
        end

        if (err && STOP_EN) begin
          state_nxt = DONE;
        end else if (cout) begin
          if (elem_idx == LAST_ELEM) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LOAD;
            elem_nxt  = elem_idx + ELEM_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they are clean flop outputs
  // yet always match the Moore decode of the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      elem_idx <= '0;
      fail     <= 1'b0;
      fail_cnt <= '0;
      ld       <= 1'b1;
      NbarT    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      elem_idx <= elem_nxt;
      fail     <= fail_nxt;
      fail_cnt <= cnt_nxt;
      ld       <= (state_nxt != TEST);
      NbarT    <= (state_nxt == LOAD) || (state_nxt == TEST);
      busy     <= (state_nxt == LOAD) || (state_nxt == TEST);
      done     <= (state_nxt == DONE);
    end
  end

endmodule
